shared_reg_arbiter: RTL and testbench

//  Round-robin arbiter sharing one W-bit synchronous-reset data register among N requesters.
//  - Each cycle at most one requester is granted; its wdata is captured into the register at the next clk edge.
//  - Sits between requesting datapath blocks and the single shared storage flop bank.
//  - Reports the current register value, its valid flag and which requester last wrote it.

---
 rtl/shared_reg_arbiter_pkg.sv | 18 +
 rtl/shared_reg_arbiter_rr_pick.sv | 47 ++++
 rtl/shared_reg_arbiter.sv | 123 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter: default sizes,
// index-width helper and the arbitration state type.
package shared_reg_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  // Keeps index ports at least one bit wide even for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_ptr,
// wrapping modulo N, found with a double-width masked priority encode.
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;
  logic           found;
  int             pos;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (int'(last_ptr) < gi);
    end
  endgenerate

  // Lower half holds only requesters above last_ptr, upper half the full set,
  // so the first set bit is the rotated winner.
  assign dbl = {req, req & hi_mask};
  assign any = |req;

  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        pos   = k;
      end
    end
    if (pos >= N) pos = pos - N;
    gnt = found ? (N'(1) << pos) : '0;
    idx = IDX_W'(pos);
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// N-requester round-robin arbiter owning one shared W-bit register.
// Define SHARED_REG_LOCK_EN to add the lock port and the LOCKED grant-holding state.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   wdata,
`ifdef SHARED_REG_LOCK_EN
  input  logic [N-1:0]     lock,
`endif
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     q,
  output logic             q_valid,
  output logic [IDX_W-1:0] owner
);

  logic [W-1:0]     q_reg;
  logic [IDX_W-1:0] owner_reg;
  logic             q_valid_reg;
  logic [IDX_W-1:0] last_ptr_reg;

  logic [N-1:0]     pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [N-1:0]     grant_vec;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [W-1:0]     wsel;

  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .last_ptr (last_ptr_reg),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

`ifdef SHARED_REG_LOCK_EN
  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] lock_id_reg, lock_id_next;
  logic             hold;

  always_comb begin
    grant_vec    = pick_gnt;
    grant_idx    = pick_idx;
    grant_any    = pick_any;
    state_next   = state_reg;
    lock_id_next = lock_id_reg;
    hold         = (state_reg == LOCKED) && req[lock_id_reg];
    if (hold) begin
      grant_vec = N'(1) << lock_id_reg;
      grant_idx = lock_id_reg;
      grant_any = 1'b1;
      if (!lock[lock_id_reg]) state_next = ARB;
    end else begin
      // Holder dropped req (or not locked): arbitrate now, no idle bubble.
      state_next = ARB;
      if (pick_any && lock[pick_idx]) begin
        state_next   = LOCKED;
        lock_id_next = pick_idx;
      end
    end
    if (!rst_n) begin
      grant_vec = '0;
      grant_any = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ARB;
      lock_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      lock_id_reg <= lock_id_next;
    end
  end
`else
  always_comb begin
    grant_vec = pick_gnt;
    grant_idx = pick_idx;
    grant_any = pick_any;
    if (!rst_n) begin
      grant_vec = '0;
      grant_any = 1'b0;
    end
  end
`endif

  always_comb begin
    wsel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_vec[i]) wsel = wsel | wdata[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg        <= '0;
      owner_reg    <= '0;
      q_valid_reg  <= 1'b0;
      last_ptr_reg <= IDX_W'(N - 1);
    end else if (grant_any) begin
      q_reg        <= wsel;
      owner_reg    <= grant_idx;
      q_valid_reg  <= 1'b1;
      last_ptr_reg <= grant_idx;
    end
  end

  assign gnt     = grant_vec;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign owner   = owner_reg;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   wdata = '0;
`ifdef SHARED_REG_LOCK_EN
  logic [N-1:0]     lock = '0;
`endif
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             q_valid;
  logic [IDX_W-1:0] owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wdata   (wdata),
`ifdef SHARED_REG_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers and a modulo scan for the winner.
  int         m_last = N - 1;
  int         m_owner = 0;
  int         m_lock_id = 0;
  logic [W-1:0] m_q = '0;
  bit         m_valid = 1'b0;
  bit         m_locked = 1'b0;
  bit         m_ready = 1'b0;

  function automatic int winner();
    int i;
    if (!rst_n) return -1;
    if (m_locked && req[m_lock_id]) return m_lock_id;
    for (int k = 1; k <= N; k++) begin
      i = (m_last + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    w = winner();
    if (m_ready) begin
      chk("model_gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
      chk("model_q", 32'(q), 32'(m_q));
      chk("model_valid", 32'(q_valid), 32'(m_valid));
      chk("model_owner", 32'(owner), 32'(m_owner));
    end
    if (!rst_n) begin
      m_q = '0; m_valid = 1'b0; m_owner = 0; m_last = N - 1;
      m_locked = 1'b0; m_ready = 1'b1;
    end else if (w >= 0) begin
`ifdef SHARED_REG_LOCK_EN
      if (m_locked && req[m_lock_id]) m_locked = lock[m_lock_id];
      else begin
        m_locked  = lock[w];
        m_lock_id = w;
      end
`endif
      m_q = wdata[w*W +: W];
      m_owner = w;
      m_valid = 1'b1;
      m_last = w;
    end else begin
      m_locked = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(8'h10 + i);

    // Reset held two cycles with every requester active
    rst_n = 1'b0;
    req = 4'b1111;
    step();
    #1 chk("rst_gnt", 32'(gnt), 32'h0);
    step();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_valid", 32'(q_valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    // Full contention: grants rotate 0,1,2,3,0,1
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 chk("rot_gnt", 32'(gnt), 32'd1 << (c % 4));
      step();
      chk("rot_q", 32'(q), 32'h10 + (c % 4));
      chk("rot_owner", 32'(owner), c % 4);
    end

    // Lone requester 2
    req = 4'b0100;
    wdata[2*W +: W] = 8'hA5;
    #1 chk("single_gnt", 32'(gnt), 32'h4);
    step();
    chk("single_q", 32'(q), 32'hA5);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_valid", 32'(q_valid), 32'h1);
    req = 4'b0000;
    #1 chk("idle_gnt", 32'(gnt), 32'h0);
    step();
    chk("hold_q", 32'(q), 32'hA5);

    // Wrap from owner 3 back to requester 0
    req = 4'b1000;
    #1 chk("to3_gnt", 32'(gnt), 32'h8);
    step();
    chk("to3_owner", 32'(owner), 32'h3);
    req = 4'b1001;
    #1 chk("wrap_gnt", 32'(gnt), 32'h1);
    step();
    chk("wrap_owner", 32'(owner), 32'h0);
    chk("wrap_q", 32'(q), 32'h10);

    // Reset overrides a live grant and restores last_ptr to N-1
    req = 4'b0010;
    #1 chk("pre_rst_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    #1 chk("rst_force_gnt", 32'(gnt), 32'h0);
    step();
    chk("rst_over_q", 32'(q), 32'h0);
    chk("rst_over_valid", 32'(q_valid), 32'h0);
    rst_n = 1'b1;
    req = 4'b1001;
    #1 chk("rst_ptr_gnt", 32'(gnt), 32'h1);
    step();
    chk("rst_ptr_q", 32'(q), 32'h10);

`ifdef SHARED_REG_LOCK_EN
    // Requester 1 locks the register against 0 and 3
    req = 4'b1011;
    lock = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      #1 chk("lock_gnt", 32'(gnt), 32'h2);
      step();
    end
    req = 4'b1001;
    lock = 4'b0000;
    #1 chk("unlock_gnt", 32'(gnt), 32'h8);
    step();
    chk("unlock_owner", 32'(owner), 32'h3);
`endif

    // Mixed patterns checked by the model only
    wdata = 32'hC3B2A190;
    req = 4'b0110; step();
    req = 4'b0101; step();
    req = 4'b1111; step(); step(); step();
    req = 4'b1010; step(); step();
    req = 4'b0000; step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
